// File: rtl/lfsr_checker.sv
// Serial PRBS checker: hunts for, verifies and then flywheels a B-bit LFSR stream,
// counting mismatches and checked bits while locked.
module lfsr_checker #(
  parameter int BITS         = 5,
  parameter int LOCK_MATCHES = 16,
  parameter int LOSS_ERRORS  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        clear_counts,
  output logic        locked,
  output logic        error_pulse,
  output logic [15:0] error_count,
  output logic [31:0] bit_count
);

  localparam int B  = (BITS < 4) ? 4 : BITS;
  localparam int FW = $clog2(B + 1);
  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int LW = $clog2(LOSS_ERRORS + 1);

  localparam logic [FW-1:0] FILL_LAST  = FW'(B - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_MATCHES - 1);
  localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_ERRORS - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [B-1:0]  hist, hist_n;
  logic [FW-1:0] fill_cnt, fill_n;
  logic [MW-1:0] match_cnt, match_n;
  logic [LW-1:0] miss_cnt, miss_n;
  logic [15:0]   err_n;
  logic [31:0]   bits_n;
  logic          pulse_n;
  logic          predicted;

  // Newest bit enters at the MSB, so hist[0] is s(k-B) and hist[2] is s(k-B+2).
  assign predicted = hist[0] ^ hist[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      hist        <= '0;
      fill_cnt    <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      locked      <= 1'b0;
      error_pulse <= 1'b0;
      error_count <= '0;
      bit_count   <= '0;
    end else begin
      state       <= state_n;
      hist        <= hist_n;
      fill_cnt    <= fill_n;
      match_cnt   <= match_n;
      miss_cnt    <= miss_n;
      locked      <= (state_n == LOCKED);
      error_pulse <= pulse_n;
      error_count <= err_n;
      bit_count   <= bits_n;
    end
  end

  always_comb begin
    state_n = state;
    hist_n  = hist;
    fill_n  = fill_cnt;
    match_n = match_cnt;
    miss_n  = miss_cnt;
    err_n   = error_count;
    bits_n  = bit_count;
    pulse_n = 1'b0;

    if (bit_valid) begin
      case (state)
        HUNT: begin
          hist_n = {bit_in, hist[B-1:1]};
          if (fill_cnt == FILL_LAST) begin
            fill_n  = '0;
            match_n = '0;
            state_n = VERIFY;
          end else begin
            fill_n = fill_cnt + 1'b1;
          end
        end

        VERIFY: begin
          hist_n = {bit_in, hist[B-1:1]};
          if (bit_in == predicted) begin
            if (match_cnt == MATCH_LAST) begin
              match_n = '0;
              miss_n  = '0;
              state_n = LOCKED;
            end else begin
              match_n = match_cnt + 1'b1;
            end
          end else begin
            match_n = '0;
          end
        end

        LOCKED: begin
          // Flywheel on the prediction so one corrupted bit costs exactly one error.
          hist_n = {predicted, hist[B-1:1]};
          if (bit_count != 32'hFFFF_FFFF) begin
            bits_n = bit_count + 32'd1;
          end
          if (bit_in != predicted) begin
            pulse_n = 1'b1;
            if (error_count != 16'hFFFF) begin
              err_n = error_count + 16'd1;
            end
            if (miss_cnt == MISS_LAST) begin
              fill_n  = '0;
              match_n = '0;
              miss_n  = '0;
              state_n = HUNT;
            end else begin
              miss_n = miss_cnt + 1'b1;
            end
          end else begin
            miss_n = '0;
          end
        end

        default: begin
          state_n = HUNT;
        end
      endcase
    end

    if (clear_counts) begin
      err_n  = '0;
      bits_n = '0;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: expected outputs are queued per driven cycle and
// compared one cycle later against a golden 5-bit LFSR stream.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        clear_counts = 1'b0;
  logic        locked;
  logic        error_pulse;
  logic [15:0] error_count;
  logic [31:0] bit_count;

  typedef struct {
    string       tag;
    logic        lck;
    logic        pls;
    logic [15:0] errc;
    logic [31:0] bitc;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [4:0] lfsr;

  lfsr_checker #(.BITS(5), .LOCK_MATCHES(16), .LOSS_ERRORS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .clear_counts (clear_counts),
    .locked       (locked),
    .error_pulse  (error_pulse),
    .error_count  (error_count),
    .bit_count    (bit_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t mkExp(input string tag, input logic l, input logic p,
                                 input int ec, input int bc);
    exp_t e;
    e.tag  = tag;
    e.lck  = l;
    e.pls  = p;
    e.errc = 16'(ec);
    e.bitc = 32'(bc);
    return e;
  endfunction

  task automatic goldenBit(output logic b);
    b    = lfsr[0];
    lfsr = {lfsr[0] ^ lfsr[2], lfsr[4:1]};
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard empty observed=0 expected=1 entries");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (locked === e.lck) else begin
        errors++;
        $error("[TB] FAIL %s locked observed=%0b expected=%0b", e.tag, locked, e.lck);
      end
      checks++;
      assert (error_pulse === e.pls) else begin
        errors++;
        $error("[TB] FAIL %s error_pulse observed=%0b expected=%0b", e.tag, error_pulse, e.pls);
      end
      checks++;
      assert (error_count === e.errc) else begin
        errors++;
        $error("[TB] FAIL %s error_count observed=%0d expected=%0d", e.tag, error_count, e.errc);
      end
      checks++;
      assert (bit_count === e.bitc) else begin
        errors++;
        $error("[TB] FAIL %s bit_count observed=%0d expected=%0d", e.tag, bit_count, e.bitc);
      end
    end
  endtask

  task automatic applyStimulus(input logic b, input logic v, input logic c, input logic r,
                               input exp_t e);
    bit_in       = b;
    bit_valid    = v;
    clear_counts = c;
    reset        = r;
    sb.push_back(e);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    clear_counts = 1'b0;
    bit_valid    = 1'b0;
    checkOutput();
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, mkExp("reset", 1'b0, 1'b0, 0, 0));
    lfsr = 5'b11111;
  endtask

  initial begin
    logic b;
    int   ec;
    int   bc;
    logic lk;

    // Clean stream: lock after valid bit 21, bit_count = n-21 afterwards.
    doReset();
    for (int n = 1; n <= 40; n++) begin
      goldenBit(b);
      applyStimulus(b, 1'b1, 1'b0, 1'b0,
                    mkExp("clean", n >= 21, 1'b0, 0, (n >= 21) ? n - 21 : 0));
    end

    // Single corrupted bit 30 while locked.
    doReset();
    for (int n = 1; n <= 40; n++) begin
      goldenBit(b);
      applyStimulus(b ^ (n == 30), 1'b1, 1'b0, 1'b0,
                    mkExp("single", n >= 21, n == 30, (n >= 30) ? 1 : 0,
                          (n >= 21) ? n - 21 : 0));
    end

    // Bits 30-33 corrupted: loss after 33, relock after 54, counts retained.
    doReset();
    for (int n = 1; n <= 60; n++) begin
      goldenBit(b);
      ec = (n < 30) ? 0 : ((n > 33) ? 4 : n - 29);
      lk = (n >= 21 && n <= 32) || (n >= 54);
      if (n <= 21)      bc = 0;
      else if (n <= 33) bc = n - 21;
      else if (n <= 54) bc = 12;
      else              bc = 12 + n - 54;
      applyStimulus(b ^ (n >= 30 && n <= 33), 1'b1, 1'b0, 1'b0,
                    mkExp("loss", lk, n >= 30 && n <= 33, ec, bc));
    end

    // Valid toggling 1/0: idle cycles hold state and clear the pulse.
    doReset();
    for (int n = 1; n <= 40; n++) begin
      goldenBit(b);
      bc = (n >= 21) ? n - 21 : 0;
      applyStimulus(b, 1'b1, 1'b0, 1'b0, mkExp("gap_valid", n >= 21, 1'b0, 0, bc));
      applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0,
                    mkExp("gap_idle", n >= 21, 1'b0, 0, bc));
    end

    // clear_counts colliding with an error, then reset while locked.
    doReset();
    for (int n = 1; n <= 30; n++) begin
      goldenBit(b);
      applyStimulus(b, 1'b1, 1'b0, 1'b0,
                    mkExp("pre_clear", n >= 21, 1'b0, 0, (n >= 21) ? n - 21 : 0));
    end
    goldenBit(b);
    applyStimulus(~b, 1'b1, 1'b1, 1'b0, mkExp("clear_collide", 1'b1, 1'b1, 0, 0));
    goldenBit(b);
    applyStimulus(b, 1'b1, 1'b0, 1'b0, mkExp("after_clear", 1'b1, 1'b0, 0, 1));
    goldenBit(b);
    applyStimulus(~b, 1'b1, 1'b1, 1'b1, mkExp("reset_locked", 1'b0, 1'b0, 0, 0));
    goldenBit(b);
    applyStimulus(~b, 1'b1, 1'b0, 1'b0, mkExp("hunt_after_reset", 1'b0, 1'b0, 0, 0));

    // All-zero stream is a legal sequence and must lock without errors.
    doReset();
    for (int n = 1; n <= 25; n++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0,
                    mkExp("zeros", n >= 21, 1'b0, 0, (n >= 21) ? n - 21 : 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter BITS, default 5, meaning LFSR width; effective width B = 4 when BITS < 4, else BITS.
REQ-002 SHALL have parameter LOCK_MATCHES, default 16, meaning consecutive correct predictions needed to declare lock.
REQ-003 SHALL have parameter LOSS_ERRORS, default 4, meaning consecutive mismatches in LOCKED that force resynchronisation.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port bit_in, input, 1, meaning the received serial PRBS bit.
REQ-007 SHALL have port bit_valid, input, 1, meaning bit_in is sampled this cycle; bits are ignored when low.
REQ-008 SHALL have port clear_counts, input, 1, meaning zero both counters; sync state is unaffected.
REQ-009 SHALL have port locked, output, 1, meaning the checker is in LOCKED.
REQ-010 SHALL have port error_pulse, output, 1, meaning a one-cycle flag for a mismatch detected while LOCKED.
REQ-011 SHALL have port error_count, output, 16, meaning mismatches counted in LOCKED; saturates at 16'hFFFF.
REQ-012 SHALL have port bit_count, output, 32, meaning valid bits checked in LOCKED; saturates at 32'hFFFFFFFF.

Function
REQ-013 SHALL check the serial stream s_k emitted as bit 0 of a B-bit LFSR that shifts right each step, with new MSB = bit0 XOR bit2; the stream therefore obeys s_k = s_(k-B) XOR s_(k-B+2).
REQ-014 SHALL hold a B-bit history H of the last B stream bits; predicted bit p = H[oldest] XOR H[oldest-2] per REQ-013.
REQ-015 SHALL update all state only on cycles with bit_valid=1, except reset and clear_counts.
REQ-016 SHALL implement the states HUNT, VERIFY and LOCKED; reset state is HUNT.
REQ-017 SHALL behave in HUNT as follows: shift bit_in into H, no comparison, increment a fill counter; on the B-th valid bit, go to VERIFY.
REQ-018 SHALL behave in VERIFY as follows: compare bit_in to p and shift bit_in into H (self-synchronising).
REQ-019 SHALL, in VERIFY, increment the match counter on a match; on reaching LOCK_MATCHES, go to LOCKED.
REQ-020 SHALL, in VERIFY, clear the match counter on a mismatch and stay in VERIFY.
REQ-021 SHALL behave in LOCKED as follows: compare bit_in to p, shift p (not bit_in) into H (flywheel), so a single corrupted bit yields exactly one error.
REQ-022 SHALL, in LOCKED, on a mismatch: pulse error_pulse, increment error_count and the consecutive-miss counter.
REQ-023 SHALL, in LOCKED, on a match: clear the consecutive-miss counter.
REQ-024 SHALL, in LOCKED, increment bit_count on every valid bit.
REQ-025 SHALL, when the consecutive-miss counter reaches LOSS_ERRORS, go to HUNT and clear the fill, match and miss counters.
REQ-026 SHALL register every output; locked and error_pulse reflect the valid bit of the preceding cycle (latency 1).
REQ-027 SHALL make locked rise on the cycle after the LOCK_MATCHES-th match, and fall on the cycle after the LOSS_ERRORS-th consecutive miss.
REQ-028 SHALL let clear_counts win over a simultaneous increment (counter reads 0 next cycle), while error_pulse still asserts.
REQ-029 SHALL hold error_count and bit_count at their maximum values once saturated, without wrapping.
REQ-030 SHALL keep error_count and bit_count across loss of lock; only reset or clear_counts zeroes them.
REQ-031 SHALL raise no error for an all-zero history; it is checked by the recurrence like any other state.

Reset
REQ-032 SHALL, on reset=1 at a rising edge, set state to HUNT; H, all internal counters, locked, error_pulse, error_count and bit_count to 0.
REQ-033 SHALL give reset priority over bit_valid and clear_counts, including mid-lock.

Verification
REQ-034 SHALL cover the clean stream case: BITS=5, 40 valid bits from a golden LFSR seeded 5'b11111 -> locked=1 the cycle after the 21st valid bit, error_count=0, bit_count=19 after bit 40.
REQ-035 SHALL cover the single error case: the same stream with bit 30 inverted -> exactly one error_pulse (cycle after bit 30), error_count=1, locked stays 1.
REQ-036 SHALL cover the loss of lock case: while locked, bits 30-33 inverted -> error_count=4, locked=0 after bit 33; re-locked after 21 further clean valid bits.
REQ-037 SHALL cover the gapped valid case: bit_valid toggling 1/0 with the clean stream -> lock on the 21st valid bit (cycle 42), same counts as the clean case.
REQ-038 SHALL cover clear collision and reset: clear_counts coincident with an error -> error_count=0 and error_pulse=1; reset asserted while locked -> next cycle all outputs 0, state HUNT.
